hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage RV core (IF/ID/EX/MEM/WB).
- Consumes the decoder's per-instruction flags and EX/MEM stage status, and drives stall/flush of every pipeline register.
- Resolves load-use hazards, control redirects, data-memory wait states, and halt entry/exit for ecall/ebreak.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_loaduse_detect.sv | 32 +++
 rtl/hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the 5-stage pipeline sequencer.
//   hz_state_t   : sequencer FSM states
//   halt_cause_t : encoding reported on halt_cause
//   RF_SEL_LOAD  : rf_wr_sel value the decoder/ctrl uses for loads
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_DRAIN    = 2'b10,
        ST_HALTED   = 2'b11
    } hz_state_t;

    typedef enum logic [1:0] {
        HC_NONE   = 2'b00,
        HC_EBREAK = 2'b01,
        HC_ECALL  = 2'b10,
        HC_MEMTO  = 2'b11
    } halt_cause_t;

    localparam logic [1:0] RF_SEL_LOAD = 2'b11;

endpackage

// File: rtl/hazard_loaduse_detect.sv
// ---------------------------------------------------------------------------
// hazard_loaduse_detect
// Purely combinational load-use compare between the instruction in EX and
// the instruction in ID.
//   id_rs1/id_rs2, id_rs1_used/id_rs2_used : ID source operands
//   ex_rd, ex_rf_wr_en, ex_rf_wr_sel       : EX destination info
//   hazard                                 : EX is a load whose rd feeds ID
// ---------------------------------------------------------------------------
module hazard_loaduse_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_rf_wr_en,
    input  logic [1:0] ex_rf_wr_sel,
    output logic       hazard
);

    logic ex_is_load;
    logic rs1_match;
    logic rs2_match;

    // x0 is never a real producer, so a load to x0 cannot create a hazard.
    assign ex_is_load = ex_rf_wr_en && (ex_rf_wr_sel == RF_SEL_LOAD) && (ex_rd != 5'd0);
    assign rs1_match  = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_match  = id_rs2_used && (id_rs2 == ex_rd);
    assign hazard     = ex_is_load && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencer for the 5-stage core. Drives stall/flush of every
// pipeline register from the FSM state and the current-cycle requests.
//   Inputs : decoder flags of the instruction in ID, EX destination/redirect,
//            MEM data-access handshake (mem_req/mem_ready), resume pulse.
//   Outputs: pc/if_id/id_ex/ex_mem stall, if_id/id_ex/mem_wb flush,
//            halted + halt_cause, saturating stall_cycles, fsm_state.
// Request priority in RUN: freeze > redirect > halt request > load-use.
// The data-memory handshake: mem_req marks an access in MEM; the access
// completes in the cycle mem_ready is high, otherwise the whole pipe holds.
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_is_syscall,
    input  logic             id_is_debug,
    input  logic [4:0]       ex_rd,
    input  logic             ex_rf_wr_en,
    input  logic [1:0]       ex_rf_wr_sel,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] stall_cycles,
    output hz_state_t        fsm_state
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    hz_state_t          state;
    halt_cause_t        cause_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [DRAIN_W-1:0] drain_cnt;

    logic lu_hazard;
    logic in_run;
    logic freeze;
    logic run_free;
    logic redirect_now;
    logic halt_req;
    logic loaduse_now;

    hazard_loaduse_detect u_loaduse (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .ex_rd        (ex_rd),
        .ex_rf_wr_en  (ex_rf_wr_en),
        .ex_rf_wr_sel (ex_rf_wr_sel),
        .hazard       (lu_hazard)
    );

    // MEM_WAIT behaves like RUN once the access completes, so both states
    // share the request evaluation below.
    assign in_run       = (state == ST_RUN) || (state == ST_MEM_WAIT);
    assign freeze       = in_run && mem_req && !mem_ready;
    assign run_free     = in_run && !freeze;
    // A redirect squashes the ID instruction, so its halt/load-use requests vanish.
    assign redirect_now = run_free && ex_redirect;
    assign halt_req     = run_free && !ex_redirect && (id_is_debug || id_is_syscall);
    assign loaduse_now  = run_free && !ex_redirect && !id_is_debug && !id_is_syscall && lu_hazard;

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        case (state)
            ST_RUN, ST_MEM_WAIT: begin
                if (freeze) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_flush = 1'b1;
                end else if (redirect_now) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                end else if (loaduse_now) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_flush  = 1'b1;
                end
            end
            ST_DRAIN, ST_HALTED: begin
                // Keep fetching nothing; bubbles flow down behind the halting op.
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end
            default: begin
                pc_stall    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            cause_q   <= HC_NONE;
            wait_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (freeze) begin
                        // The freeze cycle that brings the count to MEM_TIMEOUT
                        // aborts the access.
                        if (wait_cnt == WAIT_LAST) begin
                            state    <= ST_HALTED;
                            cause_q  <= HC_MEMTO;
                            wait_cnt <= '0;
                        end else begin
                            state    <= ST_MEM_WAIT;
                            wait_cnt <= wait_cnt + WAIT_ONE;
                        end
                    end else begin
                        wait_cnt <= '0;
                        if (halt_req) begin
                            // The halting instruction leaves ID on this edge.
                            state     <= ST_DRAIN;
                            cause_q   <= id_is_debug ? HC_EBREAK : HC_ECALL;
                            drain_cnt <= '0;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= ST_HALTED;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_ONE;
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state   <= ST_RUN;
                        cause_q <= HC_NONE;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (pc_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

    assign halted     = (state == ST_HALTED);
    assign halt_cause = cause_q;
    assign fsm_state  = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Two instances share all inputs:
//   u_dut : MEM_TIMEOUT=64, DRAIN_CYCLES=3, CNT_W=32 (main sequences)
//   u_to  : MEM_TIMEOUT=4,  DRAIN_CYCLES=3, CNT_W=3  (timeout + saturation)
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic        id_is_syscall;
    logic        id_is_debug;
    logic [4:0]  ex_rd;
    logic        ex_rf_wr_en;
    logic [1:0]  ex_rf_wr_sel;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_ready;
    logic        resume;

    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, mem_wb_flush, halted;
    logic [1:0]  halt_cause;
    logic [31:0] stall_cycles;
    hz_state_t   fsm_state;

    logic        pc_stall_t, if_id_stall_t, if_id_flush_t, id_ex_stall_t, id_ex_flush_t;
    logic        ex_mem_stall_t, mem_wb_flush_t, halted_t;
    logic [1:0]  halt_cause_t_o;
    logic [2:0]  stall_cycles_t;
    hz_state_t   fsm_state_t;

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl #(.MEM_TIMEOUT(64), .DRAIN_CYCLES(3), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_is_syscall(id_is_syscall), .id_is_debug(id_is_debug),
        .ex_rd(ex_rd), .ex_rf_wr_en(ex_rf_wr_en), .ex_rf_wr_sel(ex_rf_wr_sel),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready), .resume(resume),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_flush(mem_wb_flush), .halted(halted), .halt_cause(halt_cause),
        .stall_cycles(stall_cycles), .fsm_state(fsm_state)
    );

    hazard_ctrl #(.MEM_TIMEOUT(4), .DRAIN_CYCLES(3), .CNT_W(3)) u_to (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_is_syscall(id_is_syscall), .id_is_debug(id_is_debug),
        .ex_rd(ex_rd), .ex_rf_wr_en(ex_rf_wr_en), .ex_rf_wr_sel(ex_rf_wr_sel),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready), .resume(resume),
        .pc_stall(pc_stall_t), .if_id_stall(if_id_stall_t), .if_id_flush(if_id_flush_t),
        .id_ex_stall(id_ex_stall_t), .id_ex_flush(id_ex_flush_t), .ex_mem_stall(ex_mem_stall_t),
        .mem_wb_flush(mem_wb_flush_t), .halted(halted_t), .halt_cause(halt_cause_t_o),
        .stall_cycles(stall_cycles_t), .fsm_state(fsm_state_t)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_is_syscall = 1'b0; id_is_debug = 1'b0;
        ex_rd = 5'd0; ex_rf_wr_en = 1'b0; ex_rf_wr_sel = 2'b00; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    endtask

    task automatic set_load_in_ex(input logic [4:0] rd);
        ex_rf_wr_en = 1'b1; ex_rf_wr_sel = 2'b11; ex_rd = rd;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();

        // Reset values
        chk("rst_state",   fsm_state,    ST_RUN);
        chk("rst_pc",      pc_stall,     0);
        chk("rst_flush",   if_id_flush,  0);
        chk("rst_halted",  halted,       0);
        chk("rst_cause",   halt_cause,   0);
        chk("rst_cnt",     stall_cycles, 0);
        rst = 1'b0;
        tick();

        // Load-use on rs1: lw x5 in EX, ID reads x5
        set_load_in_ex(5'd5); id_rs1 = 5'd5; id_rs1_used = 1'b1; #1;
        chk("lu_pc",       pc_stall,    1);
        chk("lu_ifid_st",  if_id_stall, 1);
        chk("lu_idex_fl",  id_ex_flush, 1);
        chk("lu_ifid_fl",  if_id_flush, 0);
        chk("lu_exmem",    ex_mem_stall,0);
        tick();
        // Load moved to MEM, bubble in EX
        ex_rf_wr_en = 1'b0; #1;
        chk("lu_clear_pc", pc_stall,     0);
        chk("lu_cnt1",     stall_cycles, 1);
        tick();
        // rd = x0 never hazards
        set_load_in_ex(5'd0); id_rs1 = 5'd0; #1;
        chk("lu_x0_pc",    pc_stall,    0);
        chk("lu_x0_flush", id_ex_flush, 0);
        tick();
        // Load-use through rs2
        set_load_in_ex(5'd7); id_rs1 = 5'd3; id_rs2 = 5'd7; id_rs2_used = 1'b1; #1;
        chk("lu_rs2_pc",   pc_stall, 1);
        tick();
        // rs2 matches but unused
        id_rs2_used = 1'b0; #1;
        chk("lu_rs2_unused", pc_stall, 0);
        // ALU producer (not a load) matching rs1
        ex_rf_wr_sel = 2'b00; id_rs1 = 5'd7; #1;
        chk("lu_alu_pc",   pc_stall,     0);
        chk("lu_cnt2",     stall_cycles, 2);
        // resume outside HALTED is ignored
        resume = 1'b1;
        tick();
        resume = 1'b0; #1;
        chk("resume_run",  fsm_state, ST_RUN);

        // Redirect together with load-use
        set_load_in_ex(5'd5); id_rs1 = 5'd5; id_rs1_used = 1'b1; ex_redirect = 1'b1; #1;
        chk("rd_ifid_fl",  if_id_flush, 1);
        chk("rd_idex_fl",  id_ex_flush, 1);
        chk("rd_pc",       pc_stall,    0);
        chk("rd_ifid_st",  if_id_stall, 0);
        tick();
        clear_inputs(); #1;
        chk("rd_cnt",      stall_cycles, 2);

        // Five-cycle data-memory wait with a load-use also pending
        mem_req = 1'b1; mem_ready = 1'b0;
        set_load_in_ex(5'd5); id_rs1 = 5'd5; id_rs1_used = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            chk("fz_pc",     pc_stall,     1);
            chk("fz_ifid",   if_id_stall,  1);
            chk("fz_idex",   id_ex_stall,  1);
            chk("fz_exmem",  ex_mem_stall, 1);
            chk("fz_memwb",  mem_wb_flush, 1);
            chk("fz_idexfl", id_ex_flush,  0);
            if (i > 0) chk("fz_state", fsm_state, ST_MEM_WAIT);
            tick();
        end
        mem_ready = 1'b1; ex_rf_wr_en = 1'b0; #1;
        chk("fz_rel_pc",    pc_stall,     0);
        chk("fz_rel_exmem", ex_mem_stall, 0);
        chk("fz_rel_memwb", mem_wb_flush, 0);
        chk("fz_rel_state", fsm_state,    ST_MEM_WAIT);
        tick();
        clear_inputs(); #1;
        chk("fz_run",       fsm_state,    ST_RUN);
        chk("fz_cnt",       stall_cycles, 7);

        // ebreak: advances, 3 drain cycles, halted
        id_is_debug = 1'b1; #1;
        chk("eb_id_pc",     pc_stall,  0);
        chk("eb_id_state",  fsm_state, ST_RUN);
        tick();
        id_is_debug = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_redirect = (i == 1); #1;
            chk("dr_state",  fsm_state,   ST_DRAIN);
            chk("dr_pc",     pc_stall,    1);
            chk("dr_ifidfl", if_id_flush, 1);
            chk("dr_idexfl", id_ex_flush, 0);
            chk("dr_halted", halted,      0);
            chk("dr_cause",  halt_cause,  1);
            tick();
        end
        ex_redirect = 1'b0; #1;
        chk("hl_halted",    halted,      1);
        chk("hl_cause",     halt_cause,  1);
        chk("hl_pc",        pc_stall,    1);
        chk("hl_ifidfl",    if_id_flush, 1);
        tick();
        resume = 1'b1; #1;
        chk("hl_hold",      halted, 1);
        tick();
        resume = 1'b0; #1;
        chk("rs_state",     fsm_state,    ST_RUN);
        chk("rs_halted",    halted,       0);
        chk("rs_cause",     halt_cause,   0);
        chk("rs_pc",        pc_stall,     0);
        chk("rs_cnt",       stall_cycles, 12);

        // ecall, then asynchronous reset in the middle of the drain
        id_is_syscall = 1'b1;
        tick();
        id_is_syscall = 1'b0; #1;
        chk("ec_state",     fsm_state,  ST_DRAIN);
        chk("ec_cause",     halt_cause, 2);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_state",     fsm_state,    ST_RUN);
        chk("ar_pc",        pc_stall,     0);
        chk("ar_ifidfl",    if_id_flush,  0);
        chk("ar_cause",     halt_cause,   0);
        chk("ar_cnt",       stall_cycles, 0);
        tick();
        rst = 1'b0;
        tick();

        // Memory timeout on the MEM_TIMEOUT=4 instance
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_frz_pc",  pc_stall_t, 1);
            chk("to_frz_hl",  halted_t,   0);
            tick();
        end
        #1;
        chk("to_halted",    halted_t,       1);
        chk("to_cause",     halt_cause_t_o, 3);
        chk("to_state",     fsm_state_t,    ST_HALTED);
        chk("to_exmem",     ex_mem_stall_t, 0);
        chk("to_cnt4",      stall_cycles_t, 4);
        mem_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("to_sat",       stall_cycles_t, 7);
        chk("to_still_hl",  halted_t,       1);
        resume = 1'b1;
        tick();
        resume = 1'b0; #1;
        chk("to_rs_state",  fsm_state_t,    ST_RUN);
        chk("to_rs_cause",  halt_cause_t_o, 0);
        chk("to_rs_halted", halted_t,       0);
        chk("to_rs_sat",    stall_cycles_t, 7);
        chk("to_main_state", fsm_state,     ST_RUN);
        chk("to_main_cnt",  stall_cycles,   4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
